sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised, pipelined sprite-layer compositor for the Pac-Man VGA path. It supersedes the fixed single-ghost/single-Pac-Man drawing with NUM_SPR generic sprite channels, each backed by its own synchronous sprite ROM/RAM. It also adds a colour-key transparency test, strict index priority, a maze background layer, and per-frame collision flags. It sits between the VGA controller (DrawX/DrawY/blank) and the DAC outputs, with fully latency-aligned address generation and data return.

## Interface
Parameters:
- NUM_SPR, 4, number of sprite channels (2..8); channel 0 is Pac-Man.
- SPR_DIM, 26, sprite edge in pixels (square, 1..63).
- ADDR_W, 12, sprite memory address width per channel.
- H_ACTIVE, 405, playfield width; pixels with DrawX >= H_ACTIVE are forced black.
- KEY_COLOR, 24'h000000, transparent colour key.
- BG_COLOR, 24'h47B7AE, maze colour.

Ports:
- Clk  in  1  pixel clock; all logic is on its rising edge.
- Reset_n  in  1  reset, asynchronous and active-low.
- blank  in  1  1 = active video (pixel valid).
- DrawX, DrawY  in  10 each  current pixel coordinate.
- bg_on  in  1  maze mask for the current DrawX/DrawY (combinational, same cycle).
- spr_en  in  NUM_SPR  per-channel enable.
- spr_x, spr_y  in  10*NUM_SPR each  top-left corner; channel i occupies bits [10i+9:10i].
- spr_base  in  ADDR_W*NUM_SPR  frame base address (animation/direction frame).
- spr_addr  out  ADDR_W*NUM_SPR  registered read address to each sprite memory.
- spr_data  in  24*NUM_SPR  sprite memory read data, valid one clock after spr_addr.
- Red, Green, Blue  out  8 each  registered colour.
- collide  out  NUM_SPR  bit i = sprite 0 overlapped sprite i (i >= 1) during the previous frame; bit 0 is always 0.

## Operation
- Stage 0 (combinational on the inputs, registered at the edge):
  - dx = DrawX - spr_x[i], dy = DrawY - spr_y[i], in 10-bit unsigned arithmetic; a wrap makes the value large, i.e. a miss.
  - hit[i] = spr_en[i] & (dx < SPR_DIM) & (dy < SPR_DIM).
  - spr_addr[i] <= spr_base[i] + dy*SPR_DIM + dx, truncated to ADDR_W. The address is computed even on a miss; its data is discarded.
  - blank, bg_on, playfield flag (DrawX < H_ACTIVE), hit vector and a frame-start flag are registered into stage 1.
- Stage 1: memories return spr_data. Stage-1 controls are registered into stage 2 alongside spr_data.
- Stage 2, selection:
  - opaque[i] = hit[i] & (spr_data[i] != KEY_COLOR).
  - The output is the lowest-index opaque sprite; otherwise BG_COLOR if bg_on; otherwise black.
  - If blank = 0 or the pixel is outside the playfield, the output is black regardless of the other terms.
  - The chosen colour is registered onto Red/Green/Blue.
- Collision accumulator acc[NUM_SPR-1:1]:
  - Set bit i when, in stage 2, opaque[0] & opaque[i] & blank & playfield.
  - Frame-start flag = stage-0 pixel is (0,0). When it reaches stage 2: collide <= acc | this cycle's set-terms, and acc <= 0.
  - Each frame's result holds in collide until the next frame start.

## Timing
- Latency: pixel presented at edge n appears on Red/Green/Blue after edge n+3; spr_addr is valid after edge n+1.
- Throughput: one pixel per clock, no stalls, no handshake. Sprite memories must be synchronous with one-cycle read latency.
- Reset (async assert, sync release) clears all pipeline registers, spr_addr (all 0), Red/Green/Blue (0), acc and collide (0).
- Reset asserted mid-frame: outputs are black immediately. After release the first three outputs are black, because the pipeline refills with blank = 0. collide stays 0 until the next (0,0) passes stage 2.
- A sprite partially off the left or top edge (spr_x > DrawX) is clipped by the wrap rule. Right and bottom edges clip naturally.
- A spr_* change mid-frame takes effect for pixels entering stage 0 after the change; there is no double-buffering.

## Configuration
- SPRITE_COLLIDE_EN defined: the collision accumulator and collide output behave as above.
- Not defined: the accumulator is not built and collide is tied to 0. Colour output is identical in both builds.

## Test plan
- Reset: hold Reset_n = 0 with arbitrary inputs -> Red/Green/Blue = 0, spr_addr = 0, collide = 0. Release with blank = 1 -> the first non-black pixel appears exactly 3 clocks after its DrawX is presented.
- Single sprite: channel 1 at (100,50), spr_base 676; drive DrawX = 110, DrawY = 55 -> spr_addr[1] = 676 + 5*26 + 10 = 816 one clock later. ROM returns 24'hFF0000 -> Red = FF, Green = 00, Blue = 00 at n+3.
- Priority and transparency:
  - Channels 0 and 2 both hit; ch0 data is not KEY_COLOR -> ch0 colour shown.
  - ch0 data is 24'h000000 -> ch2 colour shown.
  - Both keyed and bg_on = 1 -> 47/B7/AE.
- Clipping and blanking:
  - spr_x = 1000 (wrap), DrawX = 5 -> no hit.
  - DrawX = 405 with a hit -> black.
  - blank = 0 -> black.
- Collision: ch0 and ch3 opaque-overlap at pixel (200,200) during frame k -> collide = 4'b1000 after (0,0) of frame k+1 passes stage 2. With no overlap in frame k+1, collide = 0 after frame k+2 starts.
- SPRITE_COLLIDE_EN undefined: rerun the collision scenario -> collide stays 0, and colour outputs match the enabled build cycle-for-cycle.

Source files
------------

// File: rtl/sprite_compositor.sv
// sprite_compositor: NUM_SPR colour-keyed sprite channels over a maze layer.
// The pipeline is three stages: address generation, then memory return, then
// selection into registered RGB.
// Optional build macro SPRITE_COLLIDE_EN adds the per-frame collision
// accumulator. Without it, collide is tied to 0. Colour output is the same in
// both builds.

module sprite_compositor #(
    parameter int          NUM_SPR   = 4,
    parameter int          SPR_DIM   = 26,
    parameter int          ADDR_W    = 12,
    parameter int          H_ACTIVE  = 405,
    parameter logic [23:0] KEY_COLOR = 24'h000000,
    parameter logic [23:0] BG_COLOR  = 24'h47B7AE
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      blank,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      bg_on,
    input  logic [NUM_SPR-1:0]        spr_en,
    input  logic [10*NUM_SPR-1:0]     spr_x,
    input  logic [10*NUM_SPR-1:0]     spr_y,
    input  logic [ADDR_W*NUM_SPR-1:0] spr_base,
    output logic [ADDR_W*NUM_SPR-1:0] spr_addr,
    input  logic [24*NUM_SPR-1:0]     spr_data,
    output logic [7:0]                Red,
    output logic [7:0]                Green,
    output logic [7:0]                Blue,
    output logic [NUM_SPR-1:0]        collide
);

    // Per-pixel control word carried alongside the sprite memory latency
    typedef struct packed {
        logic               blank;
        logic               bg;
        logic               play;
        logic               fs;
        logic [NUM_SPR-1:0] hit;
    } ctl_t;

    logic [NUM_SPR-1:0]        hit_d;
    logic [ADDR_W*NUM_SPR-1:0] spr_addr_d, spr_addr_q;
    ctl_t                      s1_d, s1_q, s2_d, s2_q;
    logic [NUM_SPR-1:0]        opaque;
    logic [23:0]               rgb_d, rgb_q;

    // Stage 0 per channel. A pixel left of or above the sprite gives a negative
    // offset. That offset wraps to a large unsigned value, so it misses.
    for (genvar i = 0; i < NUM_SPR; i++) begin : g_ch
        logic [9:0] dx, dy;
        assign dx       = DrawX - spr_x[10*i +: 10];
        assign dy       = DrawY - spr_y[10*i +: 10];
        assign hit_d[i] = spr_en[i] & (dx < 10'(SPR_DIM)) & (dy < 10'(SPR_DIM));
        // Address is produced even on a miss; stage 2 ignores the data then
        assign spr_addr_d[ADDR_W*i +: ADDR_W] = spr_base[ADDR_W*i +: ADDR_W]
                                              + ADDR_W'(dy) * ADDR_W'(SPR_DIM)
                                              + ADDR_W'(dx);
    end

    // Control pipeline: stage-0 terms into stage 1, stage 1 into stage 2
    always_comb begin
        s1_d       = '0;
        s1_d.blank = blank;
        s1_d.bg    = bg_on;
        s1_d.play  = (DrawX < 10'(H_ACTIVE));
        s1_d.fs    = (DrawX == 10'd0) && (DrawY == 10'd0);
        s1_d.hit   = hit_d;
        s2_d       = s1_q;
    end

    // Stage 2: spr_data is aligned with s2_q; lowest opaque index wins
    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_SPR; i++)
            opaque[i] = s2_q.hit[i] & (spr_data[24*i +: 24] != KEY_COLOR);
        rgb_d = s2_q.bg ? BG_COLOR : 24'h000000;
        for (int i = NUM_SPR - 1; i >= 0; i--)
            if (opaque[i]) rgb_d = spr_data[24*i +: 24];
        if (!s2_q.blank || !s2_q.play) rgb_d = 24'h000000;
    end

    // Pipeline and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            spr_addr_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            rgb_q      <= '0;
        end else begin
            spr_addr_q <= spr_addr_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rgb_q      <= rgb_d;
        end
    end

    assign spr_addr           = spr_addr_q;
    assign {Red, Green, Blue} = rgb_q;

`ifdef SPRITE_COLLIDE_EN
    logic [NUM_SPR-1:0] set_t, acc_d, acc_q, collide_d, collide_q;

    // Collect overlaps for the frame. Publish them on the frame-start pixel.
    always_comb begin
        set_t = '0;
        for (int i = 1; i < NUM_SPR; i++)
            set_t[i] = opaque[0] & opaque[i] & s2_q.blank & s2_q.play;
        acc_d     = acc_q | set_t;
        collide_d = collide_q;
        if (s2_q.fs) begin
            collide_d = acc_q | set_t;
            acc_d     = '0;
        end
    end

    // Collision state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_q     <= '0;
            collide_q <= '0;
        end else begin
            acc_q     <= acc_d;
            collide_q <= collide_d;
        end
    end

    assign collide = collide_q;
`else
    logic unused_fs;
    assign unused_fs = s2_q.fs;
    assign collide   = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor: a scoreboard of expected address/colour per
// driven pixel, plus directed per-feature checks.
module tb_sprite_compositor;
    localparam int          NS = 4;
    localparam logic [23:0] BG = 24'h47B7AE;
`ifdef SPRITE_COLLIDE_EN
    localparam logic [3:0]  COLL_EXP = 4'b1000;
`else
    localparam logic [3:0]  COLL_EXP = 4'b0000;
`endif

    logic        Clk, Reset_n, blank, bg_on;
    logic [9:0]  DrawX, DrawY;
    logic [3:0]  spr_en, collide;
    logic [39:0] spr_x, spr_y;
    logic [47:0] spr_base, spr_addr;
    logic [95:0] spr_data;
    logic [7:0]  Red, Green, Blue;

    logic [9:0]  sx [NS];
    logic [9:0]  sy [NS];
    logic [11:0] base [NS];
    logic [23:0] rom_col [NS];

    typedef struct { int due; logic [23:0] v; } rexp_t;
    typedef struct { int due; logic [47:0] v; } aexp_t;
    rexp_t rq[$];
    aexp_t aq[$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    sprite_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .blank(blank), .DrawX(DrawX), .DrawY(DrawY),
        .bg_on(bg_on), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
        .spr_base(spr_base), .spr_addr(spr_addr), .spr_data(spr_data),
        .Red(Red), .Green(Green), .Blue(Blue), .collide(collide)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc = cyc + 1;
    end

    always_comb begin
        spr_x = '0; spr_y = '0; spr_base = '0;
        for (int i = 0; i < NS; i++) begin
            spr_x[10*i +: 10]    = sx[i];
            spr_y[10*i +: 10]    = sy[i];
            spr_base[12*i +: 12] = base[i];
        end
    end

    // Synchronous sprite memories, one-cycle read latency, solid colour each
    always @(posedge Clk)
        for (int i = 0; i < NS; i++) spr_data[24*i +: 24] <= rom_col[i];

    function automatic logic [47:0] model_addr(input logic [9:0] x, input logic [9:0] y);
        logic [47:0] a;
        logic [9:0]  dx, dy;
        int          v;
        a = '0;
        for (int i = 0; i < NS; i++) begin
            dx = x - sx[i];
            dy = y - sy[i];
            v  = int'(base[i]) + int'(dy) * 26 + int'(dx);
            a[12*i +: 12] = v[11:0];
        end
        return a;
    endfunction

    function automatic logic [23:0] model_rgb(input logic [9:0] x, input logic [9:0] y,
                                              input logic b, input logic bg);
        logic [23:0] c;
        logic [9:0]  dx, dy;
        c = bg ? BG : 24'h0;
        for (int i = NS - 1; i >= 0; i--) begin
            dx = x - sx[i];
            dy = y - sy[i];
            if (spr_en[i] && dx < 10'd26 && dy < 10'd26 && rom_col[i] != 24'h0) c = rom_col[i];
        end
        if (!b || x >= 10'd405) c = 24'h0;
        return c;
    endfunction

    // Scoreboard: pop and compare when each expectation falls due
    initial forever begin
        aexp_t ae;
        rexp_t re;
        @(negedge Clk);
        if (Reset_n) begin
            if (aq.size() > 0 && aq[0].due == cyc) begin
                ae = aq.pop_front();
                n_checks++;
                if (spr_addr !== ae.v) $display("FAIL sb_addr cyc=%0d got=%h exp=%h", cyc, spr_addr, ae.v);
                else n_pass++;
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                re = rq.pop_front();
                n_checks++;
                if ({Red, Green, Blue} !== re.v) $display("FAIL sb_rgb cyc=%0d got=%h exp=%h", cyc, {Red, Green, Blue}, re.v);
                else n_pass++;
            end
        end
    end

    task automatic px(input logic [9:0] x, input logic [9:0] y, input logic b, input logic bg);
        @(posedge Clk); #1;
        DrawX = x; DrawY = y; blank = b; bg_on = bg;
        if (Reset_n) begin
            aq.push_back('{cyc + 1, model_addr(x, y)});
            rq.push_back('{cyc + 3, model_rgb(x, y, b, bg)});
        end
    endtask

    // Flush with blanked pixels; the last sample is unscored so config may change after
    task automatic drain();
        repeat (4) px(10'd511, 10'd511, 1'b0, 1'b0);
        @(posedge Clk); #1;
    endtask

    task automatic do_release();
        @(posedge Clk); #1;
        Reset_n = 1'b1; spr_en = 4'b0000;
        DrawX = 10'd20; DrawY = 10'd30; blank = 1'b1; bg_on = 1'b1;
        aq.push_back('{cyc + 1, model_addr(10'd20, 10'd30)});
        rq.push_back('{cyc + 1, 24'h0});
        rq.push_back('{cyc + 2, 24'h0});
        rq.push_back('{cyc + 3, BG});
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; blank = 1'b1; bg_on = 1'b1; DrawX = 10'd110; DrawY = 10'd55;
        spr_en = 4'b1111;
        for (int i = 0; i < NS; i++) begin
            sx[i] = 10'd100; sy[i] = 10'd50; base[i] = 12'd7 * 12'(i + 1);
            rom_col[i] = 24'h123456 + 24'(i);
        end
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if ({Red, Green, Blue} !== 24'h0) $display("FAIL reset_rgb got=%h exp=000000", {Red, Green, Blue}); else n_pass++;
        n_checks++;
        if (spr_addr !== 48'h0) $display("FAIL reset_addr got=%h exp=0", spr_addr); else n_pass++;
        n_checks++;
        if (collide !== 4'h0) $display("FAIL reset_collide got=%b exp=0000", collide); else n_pass++;
        do_release();
        for (int i = 0; i < 5; i++) px(10'(40 + i), 10'd60, 1'b1, 1'b1);
        // Assert reset mid-frame: colour must go black without waiting for a clock
        @(posedge Clk); #2;
        n_checks++;
        if ({Red, Green, Blue} !== BG) $display("FAIL pre_reset_rgb got=%h exp=%h", {Red, Green, Blue}, BG); else n_pass++;
        Reset_n = 1'b0;
        rq.delete();
        aq.delete();
        #1;
        n_checks++;
        if ({Red, Green, Blue} !== 24'h0) $display("FAIL midreset_rgb got=%h exp=000000", {Red, Green, Blue}); else n_pass++;
        n_checks++;
        if (spr_addr !== 48'h0) $display("FAIL midreset_addr got=%h exp=0", spr_addr); else n_pass++;
        repeat (2) @(posedge Clk);
        do_release();
        for (int i = 0; i < 4; i++) px(10'(60 + i), 10'd61, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_single();
        spr_en = 4'b0010; sx[1] = 10'd100; sy[1] = 10'd50; base[1] = 12'd676;
        rom_col[1] = 24'hFF0000;
        px(10'd110, 10'd55, 1'b1, 1'b0);
        repeat (2) @(negedge Clk);
        n_checks++;
        if (spr_addr[23:12] !== 12'd816) $display("FAIL single_addr got=%0d exp=816", spr_addr[23:12]); else n_pass++;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({Red, Green, Blue} !== 24'hFF0000) $display("FAIL single_rgb got=%h exp=ff0000", {Red, Green, Blue}); else n_pass++;
        px(10'd100, 10'd50, 1'b1, 1'b0);
        px(10'd125, 10'd75, 1'b1, 1'b0);
        px(10'd126, 10'd75, 1'b1, 1'b0);
        px(10'd100, 10'd76, 1'b1, 1'b1);
        px(10'd99, 10'd50, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_priority();
        spr_en = 4'b0101;
        sx[0] = 10'd300; sy[0] = 10'd100; base[0] = 12'd0;
        sx[2] = 10'd295; sy[2] = 10'd95;  base[2] = 12'd2000;
        rom_col[0] = 24'h00FF00; rom_col[2] = 24'h0000FF;
        px(10'd305, 10'd105, 1'b1, 1'b0);
        repeat (4) @(negedge Clk);
        n_checks++;
        if ({Red, Green, Blue} !== 24'h00FF00) $display("FAIL prio_ch0 got=%h exp=00ff00", {Red, Green, Blue}); else n_pass++;
        px(10'd296, 10'd96, 1'b1, 1'b0);
        drain();
        rom_col[0] = 24'h000000;
        px(10'd305, 10'd105, 1'b1, 1'b0);
        repeat (4) @(negedge Clk);
        n_checks++;
        if ({Red, Green, Blue} !== 24'h0000FF) $display("FAIL prio_key0 got=%h exp=0000ff", {Red, Green, Blue}); else n_pass++;
        drain();
        rom_col[2] = 24'h000000;
        px(10'd305, 10'd105, 1'b1, 1'b1);
        repeat (4) @(negedge Clk);
        n_checks++;
        if ({Red, Green, Blue} !== BG) $display("FAIL prio_bg got=%h exp=%h", {Red, Green, Blue}, BG); else n_pass++;
        px(10'd305, 10'd105, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_clip_blank();
        spr_en = 4'b0010; sx[1] = 10'd1000; sy[1] = 10'd0; base[1] = 12'd0;
        rom_col[1] = 24'hFF0000;
        px(10'd5, 10'd10, 1'b1, 1'b0);
        repeat (4) @(negedge Clk);
        n_checks++;
        if ({Red, Green, Blue} !== 24'h0) $display("FAIL clip_wrap got=%h exp=000000", {Red, Green, Blue}); else n_pass++;
        px(10'd5, 10'd10, 1'b1, 1'b1);
        drain();
        sx[1] = 10'd1020; sy[1] = 10'd10;
        px(10'd3, 10'd15, 1'b1, 1'b0);
        drain();
        sx[1] = 10'd400;
        px(10'd404, 10'd15, 1'b1, 1'b0);
        px(10'd405, 10'd15, 1'b1, 1'b1);
        repeat (4) @(negedge Clk);
        n_checks++;
        if ({Red, Green, Blue} !== 24'h0) $display("FAIL clip_playfield got=%h exp=000000", {Red, Green, Blue}); else n_pass++;
        px(10'd402, 10'd15, 1'b0, 1'b1);
        repeat (4) @(negedge Clk);
        n_checks++;
        if ({Red, Green, Blue} !== 24'h0) $display("FAIL blank_black got=%h exp=000000", {Red, Green, Blue}); else n_pass++;
        drain();
    endtask

    task automatic test_collision();
        spr_en = 4'b1001;
        sx[0] = 10'd190; sy[0] = 10'd190; base[0] = 12'd100; rom_col[0] = 24'hFFFF00;
        sx[3] = 10'd195; sy[3] = 10'd195; base[3] = 12'd900; rom_col[3] = 24'hFF00FF;
        px(10'd0, 10'd0, 1'b1, 1'b0);
        px(10'd0, 10'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) px(10'(i), 10'd0, 1'b1, 1'b0);
        @(negedge Clk);
        n_checks++;
        if (collide !== 4'b0000) $display("FAIL coll_clear got=%b exp=0000", collide); else n_pass++;
        px(10'd200, 10'd200, 1'b1, 1'b0);
        px(10'd201, 10'd201, 1'b1, 1'b0);
        px(10'd216, 10'd216, 1'b1, 1'b0);
        px(10'd0, 10'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) px(10'(i), 10'd0, 1'b1, 1'b0);
        @(negedge Clk);
        n_checks++;
        if (collide !== COLL_EXP) $display("FAIL coll_set got=%b exp=%b", collide, COLL_EXP); else n_pass++;
        px(10'd200, 10'd200, 1'b0, 1'b0);
        px(10'd50, 10'd50, 1'b1, 1'b1);
        px(10'd216, 10'd216, 1'b1, 1'b1);
        @(negedge Clk);
        n_checks++;
        if (collide !== COLL_EXP) $display("FAIL coll_hold got=%b exp=%b", collide, COLL_EXP); else n_pass++;
        px(10'd0, 10'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) px(10'(i), 10'd0, 1'b1, 1'b0);
        @(negedge Clk);
        n_checks++;
        if (collide !== 4'b0000) $display("FAIL coll_next got=%b exp=0000", collide); else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            spr_en = 4'($urandom_range(1, 15));
            for (int i = 0; i < NS; i++) begin
                sx[i] = 10'(r * 340 + $urandom_range(40, 110));
                sy[i] = 10'($urandom_range(40, 110));
                base[i] = 12'($urandom_range(0, 4095));
                rom_col[i] = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom_range(1, 24'hFFFFFF));
            end
            for (int k = 0; k < 150; k++)
                px(10'(r * 340 + $urandom_range(30, 145)), 10'($urandom_range(30, 145)),
                   1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_clip_blank();
        test_collision();
        test_back_to_back();
        repeat (4) @(negedge Clk);
        n_checks++;
        if (rq.size() != 0 || aq.size() != 0) $display("FAIL sb_drain left rgb=%0d addr=%0d exp=0", rq.size(), aq.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
